fifo_burst_packer: RTL and testbench
====================================

// Module: fifo_burst_packer
// PURPOSE
// - Drains a simple_fifo output into length-prefixed bursts for the DMA/interconnect side.
// - Each burst is one header beat (item count) followed by N data beats; out_last is asserted on the final beat.
// - A burst starts when MAX_BURST items are queued, when the FIFO stays non-empty for TIMEOUT cycles, or on flush.
// - Sits directly downstream of simple_fifo (consumes dout/dout_valid/dout_ready/item_count).
// PARAMETERS
// - DATA_WIDTH   32   width of FIFO data and output beats
// - COUNT_WIDTH  6    width of in_count (FIFO ADDR_WIDTH+1)
// - MAX_BURST    16   max data beats per burst; 1..2**(COUNT_WIDTH-1)
// - TIMEOUT      255  idle cycles with non-empty FIFO before a partial burst is forced; >=1
// - TIMER_WIDTH  8    timer width; must hold TIMEOUT
// PORTS
// - clk        in   1            clock
// - rst        in   1            reset, synchronous, active-high
// - flush      in   1            level; while high in IDLE, any non-zero count starts a burst next cycle
// - in_valid   in   1            FIFO dout_valid
// - in_data    in   DATA_WIDTH   FIFO dout
// - in_ready   out  1            to FIFO dout_ready
// - in_count   in   COUNT_WIDTH  FIFO item_count
// - out_valid  out  1            output beat valid
// - out_data   out  DATA_WIDTH   header or data beat
// - out_last   out  1            final beat of burst
// - out_ready  in   1            downstream accept
// - busy       out  1            FSM not in IDLE
// - timeout_hit out 1            one-cycle pulse when a burst is started by timeout
// BEHAVIOUR
// - Reset: state=IDLE, timer=0, len=0, beat_cnt=0; in_ready=0, out_valid=0, out_last=0, busy=0, timeout_hit=0.
// - States: IDLE -> HDR -> DATA -> IDLE.
// - IDLE:
//   - timer increments (saturating at TIMEOUT) each cycle in_count!=0; clears when in_count==0.
//   - Start condition (registered, takes effect next cycle): in_count>=MAX_BURST | (in_count!=0 & timer==TIMEOUT) | (in_count!=0 & flush).
//   - On start: len <= min(in_count, MAX_BURST), timer <= 0, go HDR.
//   - timeout_hit pulses only if the count and flush conditions were both false.
// - HDR:
//   - out_valid=1, out_data={zero-extend, len}, out_last=0, in_ready=0.
//   - On out_ready: go DATA, beat_cnt <= 0.
// - DATA:
//   - out_valid=in_valid, out_data=in_data, in_ready=out_ready (pass-through; no extra latency, no buffering).
//   - out_last = (beat_cnt==len-1).
//   - Each out_valid&out_ready: beat_cnt++. On the last beat go IDLE.
// - len is latched at start; items enqueued mid-burst are not added to it.
// - in_count lags dequeue by one cycle. IDLE is entered only after the last dequeue, so the first start evaluation uses a settled count.
// - in_valid is expected high throughout DATA (items were counted). If it drops, out_valid drops with it and the FSM waits; it never emits a phantom beat.
// - Header and every beat hold stable while out_valid & !out_ready (AXI-Stream rule).
// - rst mid-burst: immediate return to IDLE; a partially sent burst is abandoned. Upstream FIFO shares rst.
// - MAX_BURST == in_count == FIFO depth case must work: len = MAX_BURST, no width overflow in len (COUNT_WIDTH bits).
// STRUCTURE
// - Shared package: state encoding localparams (ST_IDLE/ST_HDR/ST_DATA), header field width/offset constants.
// - One sub-module natural: burst_timeout_timer (saturating counter with clear, enable, hit output).
// - Otherwise a single FSM plus counters; no memories.
// TESTING
// - Push 16 items 0..15 into FIFO (MAX_BURST=16), out_ready=1 -> header 16, then 0..15, out_last on 15, timeout_hit=0.
// - Push 3 items, no more -> after 255 idle cycles: header 3, data, out_last on 3rd beat, timeout_hit one pulse.
// - Push 2 items, assert flush at cycle 10 -> header 2 within 2 cycles, no timeout_hit.
// - 20 items queued, random out_ready backpressure -> header 16 + 16 beats, then a header 4 burst on timeout; data order intact, stable under stall.
// - Keep enqueuing during DATA -> current burst length unchanged; excess items go to the next burst.
// - Assert rst at the 5th data beat -> out_valid=0 next cycle, busy=0, FIFO empty, no out_last; normal burst afterwards.

Source files
------------

// File: rtl/fifo_burst_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_packer_pkg
// Brief    : State encoding and header layout shared by the burst packer.
// Revision : 1.0
// ============================================================================
package fifo_burst_packer_pkg;

    localparam int unsigned c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_HDR  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA = 2'd2;

    // The header beat carries the burst length starting at this bit, zero-filled elsewhere.
    localparam int unsigned c_HDR_LEN_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/fifo_burst_packer_timer.sv
`default_nettype none
// ============================================================================
// Module   : burst_timeout_timer
// Brief    : Saturating idle counter with clear; hit is high while at limit.
// Revision : 1.0
// ============================================================================
module burst_timeout_timer #(
    parameter int TIMEOUT     = 255,
    parameter int TIMER_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);

    localparam logic [TIMER_WIDTH-1:0] c_LIMIT = TIMER_WIDTH'(TIMEOUT);

    logic [TIMER_WIDTH-1:0] r_count;

    // Clear wins over enable so a burst start always restarts the idle window.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + TIMER_WIDTH'(1);
        end
    end

    assign o_hit = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/fifo_burst_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_packer
// Brief    : Drains a FIFO into length-prefixed bursts (header + N data beats).
// Revision : 1.0
// ============================================================================
module fifo_burst_packer
    import fifo_burst_packer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 6,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT     = 255,
    parameter int TIMER_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    input  logic [COUNT_WIDTH-1:0] in_count,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   timeout_hit
);

    localparam logic [COUNT_WIDTH-1:0] c_MAX_LEN = COUNT_WIDTH'(MAX_BURST);

    logic [c_STATE_W-1:0]   r_state;
    logic [COUNT_WIDTH-1:0] r_len;
    logic [COUNT_WIDTH-1:0] r_beat_cnt;
    logic                   r_timeout_hit;

    logic                   w_idle;
    logic                   w_nonempty;
    logic                   w_count_cond;
    logic                   w_flush_cond;
    logic                   w_timer_hit;
    logic                   w_start;
    logic [COUNT_WIDTH-1:0] w_start_len;
    logic                   w_last;
    logic                   w_beat;
    logic [DATA_WIDTH-1:0]  w_hdr_word;

    assign w_idle       = (r_state == c_ST_IDLE);
    assign w_nonempty   = (in_count != '0);
    assign w_count_cond = (in_count >= c_MAX_LEN);
    assign w_flush_cond = w_nonempty && flush;
    assign w_start      = w_idle && (w_count_cond || (w_nonempty && w_timer_hit) || w_flush_cond);
    assign w_start_len  = w_count_cond ? c_MAX_LEN : in_count;
    assign w_last       = (r_beat_cnt == (r_len - COUNT_WIDTH'(1)));
    assign w_beat       = (r_state == c_ST_DATA) && in_valid && out_ready;

    burst_timeout_timer #(
        .TIMEOUT     (TIMEOUT),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_idle || !w_nonempty || w_start),
        .i_enable (w_idle && w_nonempty),
        .o_hit    (w_timer_hit)
    );

    always_comb begin
        w_hdr_word = '0;
        w_hdr_word[c_HDR_LEN_LSB +: COUNT_WIDTH] = r_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_len         <= '0;
            r_beat_cnt    <= '0;
            r_timeout_hit <= 1'b0;
        end else begin
            r_timeout_hit <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_len         <= w_start_len;
                        r_state       <= c_ST_HDR;
                        r_timeout_hit <= !w_count_cond && !w_flush_cond;
                    end
                end
                c_ST_HDR: begin
                    if (out_ready) begin
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + COUNT_WIDTH'(1);
                        if (w_last) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Data beats are a straight pass-through of the FIFO head; no skid buffer.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        case (r_state)
            c_ST_HDR: begin
                out_valid = 1'b1;
                out_data  = w_hdr_word;
            end
            c_ST_DATA: begin
                out_valid = in_valid;
                out_data  = in_data;
                out_last  = w_last;
                in_ready  = out_ready;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign busy        = !w_idle;
    assign timeout_hit = r_timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_packer
// Brief    : Directed bench for fifo_burst_packer with a behavioural FIFO source.
// Revision : 1.0
// ============================================================================
module tb_fifo_burst_packer;

    localparam int DW = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [CW-1:0] in_count;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          timeout_hit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_burst_packer #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW),
        .MAX_BURST   (16),
        .TIMEOUT     (255),
        .TIMER_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .in_count    (in_count),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_hit (timeout_hit)
    );

    // Upstream FIFO: count updates on the same edge as the push/pop.
    logic [DW-1:0] mem [0:31];
    logic [4:0]    wp, rp;
    logic [CW-1:0] cnt;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_en) begin
                mem[wp] <= push_data;
                wp      <= wp + 5'd1;
            end
            if (in_valid && in_ready) rp <= rp + 5'd1;
            cnt <= cnt + CW'(push_en) - CW'(in_valid && in_ready);
        end
    end

    assign in_valid = (cnt != '0);
    assign in_data  = mem[rp];
    assign in_count = cnt;

    // Output monitor: accepted beats, timeout pulses, stall-stability violations.
    logic [DW-1:0] mon_data [$];
    logic          mon_last [$];
    int            tp_cnt = 0;
    int            stall_err = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err <= stall_err + 1;
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            if (out_valid && out_ready) begin
                mon_data.push_back(out_data);
                mon_last.push_back(out_last);
            end
            if (timeout_hit) tp_cnt <= tp_cnt + 1;
        end
    end

    task automatic push_seq(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            push_en   = 1'b1;
            push_data = first + DW'(i);
        end
        @(posedge clk); #1;
        push_en = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (mon_data.size() >= target && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (out_last !== 1'b0)    begin bad++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (timeout_hit !== 1'b0) begin bad++; $display("FAIL reset_timeout_hit: got %b expected 0", timeout_hit); end
        total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_burst();
        int base, tb0;
        bit ok;
        logic [DW-1:0] exp_d;
        logic exp_l;
        base = mon_data.size();
        tb0  = tp_cnt;
        out_ready = 1'b1;
        push_seq(32'd0, 16);
        wait_beats(base + 17, 300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL full_done: got %0d beats expected 17", mon_data.size() - base); end
        if (ok) begin
            total++; if (mon_data.size() - base !== 17) begin bad++; $display("FAIL full_count: got %0d expected 17", mon_data.size() - base); end
            for (int i = 0; i < 17; i++) begin
                exp_d = (i == 0) ? 32'd16 : 32'(i - 1);
                exp_l = (i == 16);
                total++;
                if (mon_data[base+i] !== exp_d || mon_last[base+i] !== exp_l) begin
                    bad++;
                    $display("FAIL full_beat[%0d]: got data=%0d last=%b expected data=%0d last=%b", i, mon_data[base+i], mon_last[base+i], exp_d, exp_l);
                end
            end
        end
        total++; if (tp_cnt - tb0 !== 0) begin bad++; $display("FAIL full_timeout_hit: got %0d pulses expected 0", tp_cnt - tb0); end
    endtask

    task automatic test_timeout();
        int base, tb0;
        bit ok, early;
        logic [DW-1:0] exp_d;
        logic exp_l;
        base  = mon_data.size();
        tb0   = tp_cnt;
        early = 1'b0;
        push_seq(32'd100, 3);
        repeat (200) begin
            @(negedge clk);
            if (busy) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL timeout_early_start: got busy=1 expected 0 before timeout"); end
        wait_beats(base + 4, 150, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL timeout_done: got %0d beats expected 4", mon_data.size() - base); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                exp_d = (i == 0) ? 32'd3 : 32'(99 + i);
                exp_l = (i == 3);
                total++;
                if (mon_data[base+i] !== exp_d || mon_last[base+i] !== exp_l) begin
                    bad++;
                    $display("FAIL timeout_beat[%0d]: got data=%0d last=%b expected data=%0d last=%b", i, mon_data[base+i], mon_last[base+i], exp_d, exp_l);
                end
            end
        end
        total++; if (tp_cnt - tb0 !== 1) begin bad++; $display("FAIL timeout_pulse: got %0d pulses expected 1", tp_cnt - tb0); end
    endtask

    task automatic test_flush();
        int base, tb0;
        bit ok, seen;
        logic [DW-1:0] exp_d;
        logic exp_l;
        base = mon_data.size();
        tb0  = tp_cnt;
        seen = 1'b0;
        push_seq(32'd200, 2);
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (busy && out_valid && out_data === 32'd2) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL flush_header_latency: got busy=%b data=%0d expected header 2 within 2 cycles", busy, out_data); end
        @(posedge clk); #1;
        flush = 1'b0;
        wait_beats(base + 3, 50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL flush_done: got %0d beats expected 3", mon_data.size() - base); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                exp_d = (i == 0) ? 32'd2 : 32'(199 + i);
                exp_l = (i == 2);
                total++;
                if (mon_data[base+i] !== exp_d || mon_last[base+i] !== exp_l) begin
                    bad++;
                    $display("FAIL flush_beat[%0d]: got data=%0d last=%b expected data=%0d last=%b", i, mon_data[base+i], mon_last[base+i], exp_d, exp_l);
                end
            end
        end
        total++; if (tp_cnt - tb0 !== 0) begin bad++; $display("FAIL flush_timeout_hit: got %0d pulses expected 0", tp_cnt - tb0); end
    endtask

    task automatic test_backpressure();
        int base, tb0, sb0;
        bit done;
        logic [DW-1:0] exp_d;
        logic exp_l;
        base = mon_data.size();
        tb0  = tp_cnt;
        sb0  = stall_err;
        done = 1'b0;
        out_ready = 1'b0;
        push_seq(32'd300, 20);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (mon_data.size() >= base + 22 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done: got %0d beats expected 22", mon_data.size() - base); end
        if (done) begin
            for (int i = 0; i < 22; i++) begin
                if (i == 0)       exp_d = 32'd16;
                else if (i < 17)  exp_d = 32'(299 + i);
                else if (i == 17) exp_d = 32'd4;
                else              exp_d = 32'(298 + i);
                exp_l = (i == 16) || (i == 21);
                total++;
                if (mon_data[base+i] !== exp_d || mon_last[base+i] !== exp_l) begin
                    bad++;
                    $display("FAIL bp_beat[%0d]: got data=%0d last=%b expected data=%0d last=%b", i, mon_data[base+i], mon_last[base+i], exp_d, exp_l);
                end
            end
        end
        total++; if (stall_err - sb0 !== 0) begin bad++; $display("FAIL bp_stall_stability: got %0d violations expected 0", stall_err - sb0); end
        total++; if (tp_cnt - tb0 !== 1) begin bad++; $display("FAIL bp_timeout_pulse: got %0d pulses expected 1", tp_cnt - tb0); end
    endtask

    task automatic test_enqueue_during_data();
        int base, tb0;
        bit ok;
        logic [DW-1:0] exp_d;
        logic exp_l;
        base = mon_data.size();
        tb0  = tp_cnt;
        out_ready = 1'b1;
        push_seq(32'd400, 21);
        wait_beats(base + 23, 600, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL enq_done: got %0d beats expected 23", mon_data.size() - base); end
        if (ok) begin
            for (int i = 0; i < 23; i++) begin
                if (i == 0)       exp_d = 32'd16;
                else if (i < 17)  exp_d = 32'(399 + i);
                else if (i == 17) exp_d = 32'd5;
                else              exp_d = 32'(398 + i);
                exp_l = (i == 16) || (i == 22);
                total++;
                if (mon_data[base+i] !== exp_d || mon_last[base+i] !== exp_l) begin
                    bad++;
                    $display("FAIL enq_beat[%0d]: got data=%0d last=%b expected data=%0d last=%b", i, mon_data[base+i], mon_last[base+i], exp_d, exp_l);
                end
            end
        end
        total++; if (tp_cnt - tb0 !== 1) begin bad++; $display("FAIL enq_timeout_pulse: got %0d pulses expected 1", tp_cnt - tb0); end
    endtask

    task automatic test_reset_mid_burst();
        int base, base2;
        bit found, ok, any_last;
        logic [DW-1:0] exp_d;
        logic exp_l;
        base  = mon_data.size();
        found = 1'b0;
        out_ready = 1'b1;
        push_seq(32'd500, 16);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy && out_valid && out_data === 32'd504) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rstmid_fifth_beat: got data=%0d expected 504 on a data beat", out_data); end
        #1 rst = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL rstmid_out_last: got %b expected 0", out_last); end
        total++; if (in_count !== 6'd0)  begin bad++; $display("FAIL rstmid_fifo_empty: got %0d expected 0", in_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        base2 = mon_data.size();
        any_last = 1'b0;
        for (int i = base; i < base2; i++) if (mon_last[i]) any_last = 1'b1;
        total++; if (any_last !== 1'b0) begin bad++; $display("FAIL rstmid_no_last: got out_last=1 expected none in aborted burst"); end
        push_seq(32'd600, 16);
        wait_beats(base2 + 17, 300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_after_done: got %0d beats expected 17", mon_data.size() - base2); end
        if (ok) begin
            for (int i = 0; i < 17; i++) begin
                exp_d = (i == 0) ? 32'd16 : 32'(599 + i);
                exp_l = (i == 16);
                total++;
                if (mon_data[base2+i] !== exp_d || mon_last[base2+i] !== exp_l) begin
                    bad++;
                    $display("FAIL rstmid_after_beat[%0d]: got data=%0d last=%b expected data=%0d last=%b", i, mon_data[base2+i], mon_last[base2+i], exp_d, exp_l);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_flush();
        test_backpressure();
        test_enqueue_during_data();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
